// File: rtl/overlay_pkg.sv
// Shared types and constants for the text-overlay compositor.
package overlay_pkg;

    typedef enum logic [1:0] {
        HIDDEN  = 2'd0,
        FADE_IN = 2'd1,
        SHOW    = 2'd2,
        BLINK   = 2'd3
    } state_t;

    // Text palette, {r[1:0],g[1:0],b[1:0]}
    localparam logic [5:0] PALETTE [0:7] = '{
        6'b110000,  // red
        6'b110100,  // orange
        6'b111100,  // yellow
        6'b001100,  // green
        6'b001111,  // cyan
        6'b000011,  // blue
        6'b110011,  // magenta
        6'b111111   // white
    };

    // Per-channel clamp of a palette component to the current fade level
    function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/overlay_compositor_if.sv
// Pixel-stream bundle between the overlay generators and the compositor.
interface overlay_compositor_if;
    logic       enable;
    logic       video_active;
    logic       hsync_in;
    logic       vsync_in;
    logic       overlay_active;
    logic [5:0] bg_rgb;
    logic [5:0] rgb;
    logic       hsync;
    logic       vsync;

    modport master (
        output enable, video_active, hsync_in, vsync_in, overlay_active, bg_rgb,
        input  rgb, hsync, vsync
    );

    modport slave (
        input  enable, video_active, hsync_in, vsync_in, overlay_active, bg_rgb,
        output rgb, hsync, vsync
    );
endinterface

// File: rtl/frame_tick_detect.sv
// One-cycle frame tick on the inactive->active edge of vsync.
module frame_tick_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync_in,
    output logic tick
);
    logic vsync_prev;

    // Remember last cycle's raw vsync for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vsync_prev <= 1'b0;
        else       vsync_prev <= vsync_in;
    end

    // vsync_prev resets to 0, so with active-low polarity the first falling edge still counts
    always_comb begin
        if (ACTIVE_LOW) tick = vsync_prev & ~vsync_in;
        else            tick = ~vsync_prev & vsync_in;
    end
endmodule

// File: rtl/overlay_compositor.sv
// Composites animated overlay text onto the background, 1-cycle pixel latency.
module overlay_compositor
    import overlay_pkg::*;
#(
    parameter int unsigned HIDDEN_FRAMES    = 30,
    parameter int unsigned FADE_STEP_FRAMES = 4,
    parameter int unsigned SHOW_FRAMES      = 120,
    parameter int unsigned BLINK_FRAMES     = 64,
    parameter int unsigned BLINK_LOG2       = 3,
    parameter int unsigned COLOR_SHIFT      = 4,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    overlay_compositor_if.slave  pix
);
    state_t     state, state_n;
    logic [1:0] level, level_n;
    logic [7:0] state_timer, timer_n;
    logic [7:0] frame_cnt;
    logic       tick;
    logic       text_visible;
    logic [2:0] pal_idx;
    logic [5:0] pal;
    logic [5:0] text_rgb;
    logic [5:0] pix_n;

    frame_tick_detect #(.ACTIVE_LOW(VSYNC_ACTIVE_LOW)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .vsync_in (pix.vsync_in),
        .tick     (tick)
    );

    // Free-running frame counter drives palette rotation, independent of enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     frame_cnt <= 8'd0;
        else if (tick) frame_cnt <= frame_cnt + 8'd1;
    end

    // Animation state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HIDDEN;
            level       <= 2'd0;
            state_timer <= 8'd0;
        end else begin
            state       <= state_n;
            level       <= level_n;
            state_timer <= timer_n;
        end
    end

    // Next-state: enable low overrides everything; otherwise advance only on tick
    always_comb begin
        state_n = state;
        level_n = level;
        timer_n = state_timer;
        if (!pix.enable) begin
            state_n = HIDDEN;
            level_n = 2'd0;
            timer_n = 8'd0;
        end else if (tick) begin
            timer_n = state_timer + 8'd1;
            unique case (state)
                HIDDEN: begin
                    level_n = 2'd0;
                    if (state_timer == 8'(HIDDEN_FRAMES - 1)) begin
                        state_n = FADE_IN;
                        timer_n = 8'd0;
                    end
                end
                FADE_IN: begin
                    if (state_timer == 8'(FADE_STEP_FRAMES - 1)) begin
                        level_n = level + 2'd1;
                        timer_n = 8'd0;
                        if (level == 2'd2) state_n = SHOW;
                    end
                end
                SHOW: begin
                    level_n = 2'd3;
                    if (state_timer == 8'(SHOW_FRAMES - 1)) begin
                        state_n = BLINK;
                        timer_n = 8'd0;
                    end
                end
                BLINK: begin
                    level_n = 2'd3;
                    if (state_timer == 8'(BLINK_FRAMES - 1)) begin
                        state_n = HIDDEN;
                        level_n = 2'd0;
                        timer_n = 8'd0;
                    end
                end
                default: begin
                    state_n = HIDDEN;
                    level_n = 2'd0;
                    timer_n = 8'd0;
                end
            endcase
        end
    end

    // Text colour and pixel select
    always_comb begin
        pal_idx      = 3'(frame_cnt >> COLOR_SHIFT);
        pal          = PALETTE[pal_idx];
        text_rgb     = {min2(pal[5:4], level), min2(pal[3:2], level), min2(pal[1:0], level)};
        text_visible = (state != HIDDEN) && !(state == BLINK && state_timer[BLINK_LOG2]);
        if (!pix.video_active)                       pix_n = 6'd0;
        else if (pix.overlay_active && text_visible) pix_n = text_rgb;
        else                                         pix_n = pix.bg_rgb;
    end

    // Output register; syncs share the pixel's latency so they stay aligned at the pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix.rgb   <= 6'd0;
            pix.hsync <= 1'b0;
            pix.vsync <= 1'b0;
        end else begin
            pix.rgb   <= pix_n;
            pix.hsync <= pix.hsync_in;
            pix.vsync <= pix.vsync_in;
        end
    end
endmodule

// File: tb/tb_overlay_compositor.sv
// Self-checking bench: scoreboard of expected pixels driven by a tick-count model.
module tb_overlay_compositor;
    logic clk = 1'b0;
    logic reset = 1'b1;

    overlay_compositor_if pix();

    overlay_compositor dut (
        .clk   (clk),
        .reset (reset),
        .pix   (pix)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [5:0] TB_PAL [0:7] = '{
        6'b110000, 6'b110100, 6'b111100, 6'b001100,
        6'b001111, 6'b000011, 6'b110011, 6'b111111
    };

    int  errors = 0;
    int  checks = 0;
    int  n      = 0;    // ticks counted by the animation since reset/enable
    int  fcnt   = 0;    // ticks since reset
    bit  prev_vs = 0;
    bit  en      = 1;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] cmin(input logic [1:0] a, input int l);
        return (int'(a) < l) ? a : 2'(l);
    endfunction

    // Expected pixel from position in the 226-tick animation cycle
    function automatic logic [5:0] model_pix(input bit va, input bit ov, input logic [5:0] bg);
        int p;
        int lvl;
        bit vis;
        logic [5:0] c;
        p = n % 226;
        if (p < 30)       begin vis = 0; lvl = 0; end
        else if (p < 42)  begin vis = 1; lvl = (p - 30) / 4; end
        else if (p < 162) begin vis = 1; lvl = 3; end
        else              begin lvl = 3; vis = (((p - 162) / 8) % 2) == 0; end
        c = TB_PAL[(fcnt / 16) % 8];
        if (!va)            return 6'd0;
        else if (ov && vis) return {cmin(c[5:4], lvl), cmin(c[3:2], lvl), cmin(c[1:0], lvl)};
        else                return bg;
    endfunction

    task automatic step(input bit va, input bit ov, input logic [5:0] bg, input bit vs);
        exp_t e;
        bit   hs;
        bit   t;
        hs = 1'($urandom_range(0, 1));
        pix.enable         = en;
        pix.video_active   = va;
        pix.overlay_active = ov;
        pix.bg_rgb         = bg;
        pix.hsync_in       = hs;
        pix.vsync_in       = vs;
        exp_q.push_back('{model_pix(va, ov, bg), hs, vs});
        t = prev_vs && !vs;
        if (!en)    n = 0;
        else if (t) n++;
        if (t) fcnt = (fcnt + 1) % 256;
        prev_vs = vs;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk("rgb",   pix.rgb,          e.rgb);
        chk("hsync", {5'd0, pix.hsync}, {5'd0, e.hs});
        chk("vsync", {5'd0, pix.vsync}, {5'd0, e.vs});
    endtask

    // One frame: vsync high for two pixels, then the falling edge ticks
    task automatic frame(input bit va, input bit ov);
        logic [5:0] bg;
        bg = 6'($urandom_range(0, 63));
        step(va, ov, bg, 1'b1);
        step(va, ov, bg, 1'b1);
        step(va, ov, bg, 1'b0);
        step(va, 1'b0, bg, 1'b0);
    endtask

    task automatic probe(input string tag, input logic [5:0] expv);
        step(1'b1, 1'b1, 6'b010101, 1'b0);
        chk(tag, pix.rgb, expv);
    endtask

    initial begin
        pix.enable = 1'b1; pix.video_active = 1'b1; pix.overlay_active = 1'b1;
        pix.bg_rgb = 6'b010101; pix.hsync_in = 1'b1; pix.vsync_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rgb",   pix.rgb,           6'd0);
        chk("reset_hsync", {5'd0, pix.hsync}, 6'd0);
        chk("reset_vsync", {5'd0, pix.vsync}, 6'd0);
        reset = 1'b0;

        probe("hidden_bg", 6'b010101);
        repeat (29) frame(1'b1, 1'b1);
        probe("hidden_29", 6'b010101);
        frame(1'b1, 1'b1);
        probe("fade_lvl0", 6'b000000);
        repeat (4) frame(1'b1, 1'b1);
        probe("fade_lvl1", 6'b010100);
        repeat (4) frame(1'b1, 1'b1);
        probe("fade_lvl2", 6'b101000);
        repeat (4) frame(1'b1, 1'b1);
        probe("show_yellow", 6'b111100);
        step(1'b0, 1'b1, 6'b101010, 1'b0);
        chk("va0_black", pix.rgb, 6'd0);
        repeat (18) frame(1'b1, 1'b1);
        repeat (2)  frame(1'b0, 1'b1);
        repeat (18) frame(1'b1, 1'b1);
        probe("show_blue", 6'b000011);
        repeat (82) frame(1'b1, 1'b1);
        probe("blink_on", 6'b111100);
        repeat (8) frame(1'b1, 1'b1);
        probe("blink_off", 6'b010101);
        repeat (8) frame(1'b1, 1'b1);
        probe("blink_on2", 6'b001100);
        repeat (48) frame(1'b1, 1'b1);
        probe("hidden_again", 6'b010101);

        // Into SHOW of the second cycle, then drop enable on a tick
        repeat (54) frame(1'b1, 1'b1);
        step(1'b1, 1'b1, 6'b010101, 1'b1);
        step(1'b1, 1'b1, 6'b010101, 1'b1);
        en = 0;
        step(1'b1, 1'b1, 6'b010101, 1'b0);
        en = 1;
        probe("en_drop_hidden", 6'b010101);
        repeat (29) frame(1'b1, 1'b1);
        probe("reen_29", 6'b010101);
        frame(1'b1, 1'b1);
        probe("reen_fade", 6'b000000);
        repeat (12) frame(1'b1, 1'b1);
        probe("reen_show_cyan", 6'b001111);

        // Asynchronous reset mid-line with text being drawn
        pix.hsync_in = 1'b1; pix.vsync_in = 1'b1;
        reset = 1'b1;
        #1;
        chk("midrst_rgb",   pix.rgb,           6'd0);
        chk("midrst_hsync", {5'd0, pix.hsync}, 6'd0);
        chk("midrst_vsync", {5'd0, pix.vsync}, 6'd0);
        exp_q.delete();
        n = 0; fcnt = 0; prev_vs = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        probe("post_rst_bg", 6'b010101);
        frame(1'b1, 1'b1);
        probe("post_rst_hidden", 6'b010101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/overlay_compositor.md
Name: overlay_compositor

Overview:
Downstream stage of the text-overlay generators. It consumes the combinational overlay_active bit plus the background colour and sync signals for the same pixel. It produces registered 2-bit-per-channel RGB with an animated text colour: a frame-driven fade-in, show, blink and hidden cycle, and a palette that rotates over time. Syncs are delayed to match the 1-cycle pixel latency so the pair drives the output pins directly.

Parameters:
HIDDEN_FRAMES, 30, frames spent in HIDDEN (1..255)
FADE_STEP_FRAMES, 4, frames per fade level step (1..255)
SHOW_FRAMES, 120, frames in SHOW (1..255)
BLINK_FRAMES, 64, frames in BLINK (1..255)
BLINK_LOG2, 3, blink half-period = 2^BLINK_LOG2 frames (0..6)
COLOR_SHIFT, 4, palette advances every 2^COLOR_SHIFT frames (0..5)
VSYNC_ACTIVE_LOW, 1, 1: frame tick on vsync_in falling edge; 0: rising edge

Ports:
clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
enable  input  1  animation enable; low forces HIDDEN
video_active  input  1  pixel is in the visible area
hsync_in  input  1  raw hsync for this pixel
vsync_in  input  1  raw vsync for this pixel
overlay_active  input  1  text bit for this pixel
bg_rgb  input  6  background {r[1:0],g[1:0],b[1:0]}
rgb  output  6  composited colour {r,g,b}, registered
hsync  output  1  hsync_in delayed 1 cycle
vsync  output  1  vsync_in delayed 1 cycle

Behaviour:
- Reset: rgb=0, hsync=0, vsync=0, state=HIDDEN, level=0, state_timer=0, frame_cnt=0, vsync_prev=0.
- Frame tick: a 1-cycle pulse when vsync_in goes from inactive to active (polarity set by VSYNC_ACTIVE_LOW), detected against vsync_prev. The first edge after reset counts.
- frame_cnt: 8-bit, +1 per tick, wraps 255->0. Palette index = frame_cnt[COLOR_SHIFT+2:COLOR_SHIFT] (3 bits).
- FSM, evaluated only on tick. state_timer is 8-bit, cleared on every state change, otherwise +1 per tick.
  - HIDDEN: level=0. When state_timer==HIDDEN_FRAMES-1, go to FADE_IN.
  - FADE_IN: when state_timer==FADE_STEP_FRAMES-1, level increments and state_timer clears. The tick on which level becomes 3 also moves to SHOW. Total duration is 3*FADE_STEP_FRAMES ticks.
  - SHOW: level=3. When state_timer==SHOW_FRAMES-1, go to BLINK.
  - BLINK: level=3. Text is visible while state_timer[BLINK_LOG2]==0. When state_timer==BLINK_FRAMES-1, go to HIDDEN with level=0.
- enable low: the next clock forces state=HIDDEN, level=0, state_timer=0, regardless of tick. enable rising resumes counting from HIDDEN. frame_cnt keeps running regardless of enable.
- text_visible = (state != HIDDEN) && !(state==BLINK && state_timer[BLINK_LOG2]).
- Text colour: each channel = min(palette[idx].ch, level), 2-bit unsigned.
- Pixel path, 1-cycle latency from inputs to rgb/hsync/vsync:
  - video_active=0 -> rgb=0.
  - else overlay_active && text_visible -> text colour.
  - else -> bg_rgb.
- Simultaneous tick and enable low: enable low wins.
- A tick coinciding with a timer terminal value produces exactly one transition. A tick cannot occur twice without vsync going inactive.
- Reset asserted mid-frame: all outputs clear immediately (async), with no residual state.

Decomposition:
- Package overlay_pkg holds:
  - the state enum (HIDDEN, FADE_IN, SHOW, BLINK);
  - localparam PALETTE[0:7] of 6-bit colours: red 110000, orange 110100, yellow 111100, green 001100, cyan 001111, blue 000011, magenta 110011, white 111111;
  - a function min2(a,b) on 2-bit values.
- One sub-module, frame_tick_detect (vsync edge detector producing the tick, parameterised by polarity), is natural. FSM and pixel mux stay in the top.

Test Plan:
- Reset mid-line with video_active=1, overlay_active=1 -> rgb=000000, hsync=vsync=0 on the same cycle. Defaults HIDDEN, so after release rgb equals bg_rgb (e.g. 010101) with 1-cycle latency.
- enable=1, count falling vsync edges -> FADE_IN entered after tick 30. Text channel max is 1, 2, 3 after ticks 34, 38, 42. SHOW entered on tick 42.
- In SHOW at frame_cnt=0x20 (idx 2, yellow), overlay_active=1 -> rgb=111100. At frame_cnt=0x50 (idx 5) -> rgb=000011.
- BLINK entered after 120 SHOW ticks -> text shown for 8 ticks, bg for 8 ticks, alternating. HIDDEN reached after 64 ticks.
- video_active=0 with overlay_active=1 in SHOW -> rgb=000000. hsync/vsync outputs equal the inputs delayed by exactly 1 clock.
- enable dropped during SHOW on the same cycle as a tick -> state=HIDDEN, level=0 next clock. Re-enable -> 30 ticks before FADE_IN. frame_cnt is unaffected.
